// File: rtl/instr_fetch_unit.sv
// Fetch stage of the 8-bit teaching CPU.
// Owns the program counter, addresses the combinational program ROM,
// captures the returned byte into the instruction register and offers it
// to execute over a valid/ready handshake. Supports run/halt control and
// a jump redirect that is taken when the handshake completes.
module instr_fetch_unit #(
  parameter int PC_W  = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             halt,
  output logic [PC_W-1:0]  rom_addr,
  input  logic [7:0]       rom_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [7:0]       instr,
  output logic [2:0]       opcode,
  output logic [1:0]       rd,
  output logic [2:0]       rs,
  output logic [PC_W-1:0]  instr_pc,
  input  logic             jump_en,
  input  logic [PC_W-1:0]  jump_addr,
  output logic             pc_wrap,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } state_e;

  state_e             state_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    instr_pc_q;
  logic [7:0]         instr_q;
  logic               valid_q;
  logic               wrap_q;
  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               hs_s;
  logic [PC_W-1:0]    pc_inc_s;
  logic               pc_at_max_s;

  // valid_q is only ever set in S_VALID, so the handshake is implicitly gated
  assign hs_s        = valid_q & instr_ready;
  assign pc_inc_s    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
  assign pc_at_max_s = (pc_q == {PC_W{1'b1}});

  // ROM is addressed straight from the PC; there is no address register
  assign rom_addr    = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[7:5];
  assign rd          = instr_q[4:3];
  assign rs          = instr_q[2:0];
  assign instr_pc    = instr_pc_q;
  assign pc_wrap     = wrap_q;
  assign retired_cnt = cnt_q;
  assign busy        = busy_q;

  // Fetch FSM with PC, instruction register, wrap pulse and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= {PC_W{1'b0}};
      instr_pc_q <= {PC_W{1'b0}};
      instr_q    <= 8'h00;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      wrap_q <= 1'b0;
      if (hs_s) begin
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      case (state_q)
        S_IDLE: begin
          // PC is kept so a halted program resumes where it stopped
          if (run) begin
            state_q <= S_FETCH;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: begin
          instr_q    <= rom_data;
          instr_pc_q <= pc_q;
          pc_q       <= pc_inc_s;
          wrap_q     <= pc_at_max_s;
          valid_q    <= 1'b1;
          state_q    <= S_VALID;
        end
        S_VALID: begin
          if (hs_s) begin
            if (jump_en) begin
              // Redirect: the ROM needs a cycle at the new address (bubble)
              pc_q    <= jump_addr;
              valid_q <= 1'b0;
              if (halt) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_FETCH;
              end
            end else if (halt) begin
              state_q <= S_IDLE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              // Back-to-back fetch keeps one instruction per cycle
              instr_q    <= rom_data;
              instr_pc_q <= pc_q;
              pc_q       <= pc_inc_s;
              wrap_q     <= pc_at_max_s;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the 8-bit teaching CPU.
- Owns the 3-bit program counter, drives the address input of the 8-entry program ROM (combinational read, zero latency), and captures the returned byte into an instruction register.
- Splits the captured byte into opcode[7:5], rd[4:3] and rs[2:0], and hands it to the decode/execute stage over a valid/ready handshake.
- Supports run/halt control and single-cycle jump redirect from execute.

Parameters:
- PC_W, 3, program counter / ROM address width (8 instructions)
- CNT_W, 8, width of the retired-instruction counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- run  input  1  level; leaves IDLE and starts fetching
- halt  input  1  level; stops fetching at the next handshake
- rom_addr  output  PC_W  ROM address, always equals pc
- rom_data  input  8  ROM read data, combinational from rom_addr
- instr_valid  output  1  instruction register holds a valid instruction
- instr_ready  input  1  execute stage accepts the instruction
- instr  output  8  instruction register
- opcode  output  3  instr[7:5]
- rd  output  2  instr[4:3]
- rs  output  3  instr[2:0]
- instr_pc  output  PC_W  address the current instr was fetched from
- jump_en  input  1  redirect request, sampled only on handshake
- jump_addr  input  PC_W  redirect target
- pc_wrap  output  1  one-cycle pulse when pc increments from 7 to 0
- retired_cnt  output  CNT_W  count of handshakes, wraps modulo 2^CNT_W
- busy  output  1  high when state != IDLE

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE, pc=0, instr=0x00, instr_pc=0
  - instr_valid=0, pc_wrap=0, retired_cnt=0, busy=0
- The deassertion edge has no other effect.
- Handshake (hs) = instr_valid & instr_ready, evaluated on the rising clk edge.
- FSM states:
  - IDLE: instr_valid=0. If run=1, go to FETCH; pc is kept, so a halted program resumes where it stopped. halt is ignored in IDLE.
  - FETCH: instr<=rom_data, instr_pc<=pc, pc<=pc+1 (mod 8). Go to VALID. Exactly one cycle; halt and jump_en are ignored here.
  - VALID: instr_valid=1. instr, opcode, rd, rs and instr_pc stay stable until hs. With no hs, state and pc hold.
- On hs in VALID (priority order):
  1. If jump_en=1: pc<=jump_addr. The next state is IDLE if halt=1, else FETCH, which inserts one bubble cycle.
  2. Else if halt=1: go to IDLE. pc already points at the next instruction.
  3. Else, back-to-back fetch: instr<=rom_data, instr_pc<=pc, pc<=pc+1, stay in VALID. Throughput is 1 instruction per cycle.
- Any hs increments retired_cnt by 1, wrapping 255->0.
- pc_wrap=1 for exactly one cycle after any increment of pc from 7 to 0. A jump load never sets pc_wrap.
- rom_addr = pc combinationally. No register sits between pc and the ROM.
- Fetch latency: run asserted in cycle N (IDLE) -> instr_valid=1 in cycle N+2.
- Codes 110 and 111 are passed through undecoded; legality is execute's concern.
- Reset asserted mid-operation (any state) aborts immediately, with all outputs at their reset values. No partial instruction is presented afterwards.

Test Plan:
- Reset then run=1, instr_ready=1, ROM programmed 0x08,0x19,0x4A,0x63,0x84,0xA8,0x00,0x00 -> valid from cycle 2:
  - instr sequence 0x08,0x19,0x4A,... one per cycle
  - instr_pc 0..7
  - addr 2 decodes opcode=010, rd=01, rs=010
- Continuous run past addr 7 -> pc_wrap pulses once as pc 7->0; next instr 0x08 with instr_pc=0; retired_cnt=9 after 9 handshakes.
- instr_ready held 0 for 3 cycles with instr 0x4A presented -> instr, instr_pc=2 and pc=3 all stable; then ready=1 -> 0x63 next cycle.
- hs on instr_pc=1 with jump_en=1, jump_addr=5 -> one bubble (instr_valid=0), then instr=0xA8 (opcode=101, rd=01, rs=000), instr_pc=5.
- halt=1 at hs on instr_pc=3 -> IDLE, busy=0, pc=4; run=1 later -> instr=0x84 with instr_pc=4.
- rst_n pulled low while in VALID at instr_pc=6 -> immediately instr_valid=0, pc=0, retired_cnt=0; after release with run=1, first instr=0x08.
